// File: rtl/alu_rb_sequencer_pkg.sv
// rtl/alu_rb_sequencer_pkg.sv - shared constants, field positions and state encoding
package seq_pkg;

    localparam logic [3:0] CLS_ALU = 4'd0;
    localparam logic [3:0] CLS_LI  = 4'd1;
    localparam logic [3:0] CLS_NOP = 4'd2;

    localparam int CLS_LSB = 28;
    localparam int OP_LSB  = 24;
    localparam int RD_LSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_LSB  = 12;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        WB_IMM
    } state_t;

endpackage

// File: rtl/alu_rb_sequencer_if.sv
// rtl/alu_rb_sequencer_if.sv - instruction valid/ready handshake
interface alu_rb_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;

    modport master (output in_valid, output instr, input in_ready);
    modport slave  (input in_valid, input instr, output in_ready);

endinterface

// File: rtl/alu_rb_sequencer_decoder.sv
// rtl/alu_rb_sequencer_decoder.sv - combinational instruction field decoder
module seq_instr_decoder
    import seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    output logic [3:0]       cls,
    output logic             is_illegal,
    output logic [3:0]       alu_op,
    output logic [3:0]       rd,
    output logic [3:0]       rs,
    output logic [3:0]       rt,
    output logic [WIDTH-1:0] imm
);

    logic [15:0] imm16;

    assign cls        = instr[CLS_LSB +: 4];
    assign alu_op     = instr[OP_LSB +: 4];
    assign rd         = instr[RD_LSB +: 4];
    assign rs         = instr[RS_LSB +: 4];
    assign rt         = instr[RT_LSB +: 4];
    assign imm16      = instr[IMM_LSB +: 16];
    assign imm        = {{(WIDTH-16){imm16[15]}}, imm16};
    assign is_illegal = (cls != CLS_ALU) && (cls != CLS_LI) && (cls != CLS_NOP);

endmodule

// File: rtl/alu_rb_sequencer.sv
// rtl/alu_rb_sequencer.sv - non-pipelined control sequencer for the ALU/register-bank datapath
module alu_rb_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int WIDTH       = 32,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_rb_sequencer_if.slave     bus,
    output logic [3:0]            alu_op,
    output logic                  read_port_1,
    output logic                  read_port_2,
    output logic                  write_port,
    output logic                  W,
    output logic [ADDR_WIDTH-1:0] addr_port_1,
    output logic [ADDR_WIDTH-1:0] addr_port_2,
    output logic [ADDR_WIDTH-1:0] addr_port_write,
    output logic [WIDTH-1:0]      external_write,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic [15:0]           retired
);

    if (ADDR_WIDTH != 4) begin : g_bad_addr_width
        $error("alu_rb_sequencer: ADDR_WIDTH must be 4");
    end
    if (EXEC_CYCLES < 1 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
        $error("alu_rb_sequencer: EXEC_CYCLES must be 1..15");
    end

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t                  state, state_next;
    logic [3:0]              cnt;
    logic [3:0]              op_q;
    logic [ADDR_WIDTH-1:0]   rd_q, rs_q, rt_q;
    logic [WIDTH-1:0]        imm_q;
    logic                    accept, done_next;

    logic [3:0]              dec_cls, dec_op, dec_rd, dec_rs, dec_rt;
    logic                    dec_illegal;
    logic [WIDTH-1:0]        dec_imm;

    seq_instr_decoder #(.WIDTH(WIDTH)) u_decoder (
        .instr      (bus.instr),
        .cls        (dec_cls),
        .is_illegal (dec_illegal),
        .alu_op     (dec_op),
        .rd         (dec_rd),
        .rs         (dec_rs),
        .rt         (dec_rt),
        .imm        (dec_imm)
    );

    assign bus.in_ready = (state == IDLE);
    assign accept       = bus.in_valid && (state == IDLE);
    assign done_next    = (accept && dec_cls == CLS_NOP) || state == WB || state == WB_IMM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && dec_cls == CLS_ALU)     state_next = READ;
                else if (accept && dec_cls == CLS_LI) state_next = WB_IMM;
            end
            READ:    state_next = EXEC;
            EXEC:    if (cnt == 4'd0) state_next = WB;
            WB:      state_next = IDLE;
            WB_IMM:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Fields are latched on every accept; IDLE gating hides them for NOP/illegal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            done    <= done_next;
            illegal <= accept && dec_illegal;
            if (done_next) retired <= retired + 16'd1;
            if (accept) begin
                op_q  <= dec_op;
                rd_q  <= dec_rd;
                rs_q  <= dec_rs;
                rt_q  <= dec_rt;
                imm_q <= dec_imm;
            end
            if (state == READ)                    cnt <= EXEC_LOAD;
            else if (state == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        busy            = (state != IDLE);
        alu_op          = '0;
        addr_port_1     = '0;
        addr_port_2     = '0;
        addr_port_write = '0;
        read_port_1     = 1'b0;
        read_port_2     = 1'b0;
        write_port      = 1'b0;
        W               = 1'b0;
        external_write  = '0;
        if (busy) begin
            alu_op          = op_q;
            addr_port_1     = rs_q;
            addr_port_2     = rt_q;
            addr_port_write = rd_q;
        end
        if (state == READ) begin
            read_port_1 = 1'b1;
            read_port_2 = 1'b1;
        end
        if (state == WB) write_port = 1'b1;
        if (state == WB_IMM) begin
            write_port     = 1'b1;
            W              = 1'b1;
            external_write = imm_q;
        end
    end

endmodule

// File: doc/alu_rb_sequencer.md
Name: alu_rb_sequencer

Overview:
- Control stage directly upstream of the ALU/register-bank datapath (`alu_reg_bank`).
- Accepts 32-bit instructions over a valid/ready handshake and decodes them.
- Sequences the datapath controls (`alu_op`, read/write port enables, addresses, `W`, `external_write`) through read, execute and writeback cycles.
- Reports completion, illegal opcodes and a retired-instruction count.

Parameters:
- ADDR_WIDTH, 4, register address width; must equal 4 to match the instruction fields (elaboration check).
- WIDTH, 32, datapath width; immediate is sign-extended to WIDTH.
- EXEC_CYCLES, 2, cycles between read strobe and writeback (bank read latency + ALU register latency); legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  instruction available.
- in_ready  output  1  sequencer can accept; high only in IDLE.
- instr  input  32  instruction word.
- alu_op  output  4  ALU operation to datapath.
- read_port_1  output  1  bank read enable A.
- read_port_2  output  1  bank read enable B.
- write_port  output  1  bank write enable.
- W  output  1  write source select: 1 = external_write, 0 = ALU result R.
- addr_port_1  output  ADDR_WIDTH  source address A.
- addr_port_2  output  ADDR_WIDTH  source address B.
- addr_port_write  output  ADDR_WIDTH  destination address.
- external_write  output  WIDTH  sign-extended immediate.
- busy  output  1  instruction in flight (state != IDLE).
- done  output  1  one-cycle pulse, instruction retired.
- illegal  output  1  one-cycle pulse, unknown class rejected.
- retired  output  16  count of retired instructions, wraps.

Behaviour:
- Instruction fields:
  - instr[31:28] class; 0 = ALU reg-reg, 1 = LI (load immediate), 2 = NOP, others illegal.
  - instr[27:24] alu_op; [23:20] rd; [19:16] rs; [15:12] rt; [15:0] imm16.
- Reset (async, any state): state IDLE. All outputs 0, except in_ready = 1. Latched instruction cleared, EXEC counter 0, retired 0.
- A reset asserted mid-instruction aborts it: no write occurs after reset assertion and nothing is retired.
- Handshake: accept when in_valid & in_ready at a rising edge; instr latched at that edge. No acceptance outside IDLE; in_valid may be held.
- States:
  - IDLE: on accept, decode the latched class:
    - ALU -> READ.
    - LI -> WB_IMM.
    - NOP -> IDLE; done pulses the next cycle and retired increments.
    - illegal -> IDLE; illegal pulses the next cycle; no retire, no bank access.
  - READ (1 cycle): read_port_1 = read_port_2 = 1, addr_port_1 = rs, addr_port_2 = rt, alu_op valid. Load counter with EXEC_CYCLES-1 -> EXEC.
  - EXEC: hold alu_op and addresses, read enables low. Decrement the counter; at 0 -> WB.
  - WB (1 cycle): write_port = 1, W = 0, addr_port_write = rd, alu_op held -> IDLE.
  - WB_IMM (1 cycle): write_port = 1, W = 1, addr_port_write = rd, external_write = sign-extend(imm16) -> IDLE.
- done and illegal are registered: they pulse in the first IDLE cycle after WB/WB_IMM, or the cycle after a NOP/illegal accept. A new instruction may be accepted in that same cycle.
- retired increments with each done; wraps 0xFFFF -> 0x0000.
- Latency, accept edge at cycle T:
  - ALU: READ at T+1, WB at T+2+EXEC_CYCLES, done at T+3+EXEC_CYCLES (default: WB T+4, done T+5).
  - LI: write at T+1, done at T+2.
  - NOP: done at T+1.
- alu_op and the address outputs are 0 in IDLE, held from the latched instruction in all other states.
- external_write is 0 except in WB_IMM.
- Back-to-back dependent instructions are safe: the sequencer is non-pipelined, so a write completes before the next read.

Decomposition:
- Shared package seq_pkg: class constants (CLS_ALU = 4'd0, CLS_LI = 4'd1, CLS_NOP = 4'd2); state encoding (IDLE, READ, EXEC, WB, WB_IMM); field bit positions.
- One combinational sub-module, seq_instr_decoder: instr in -> class, is_illegal, alu_op, rd, rs, rt, sign-extended immediate out.
- FSM, counter and output registers stay in the top module.

Test Plan:
- Reset mid-EXEC: assert rst while busy -> outputs 0, in_ready = 1, no write_port pulse, retired = 0.
- LI: instr 0x1_0_3_0_FFFE (class 1, rd = 3, imm = 0xFFFE) accepted at T -> write_port = 1, W = 1, addr_port_write = 3, external_write = 0xFFFFFFFE at T+1; done at T+2; retired = 1.
- ALU: instr class 0, alu_op = 4'h2, rd = 5, rs = 1, rt = 2 at T -> read enables with addr 1/2 at T+1; write_port = 1, W = 0, addr_port_write = 5 at T+4; done at T+5.
- Back-to-back: in_valid held high with three LI -> accepts at T, T+2, T+4; in_ready low at T+1 and T+3; retired = 3.
- Illegal: class 4'hF -> illegal pulse next cycle, no write_port, retired unchanged. NOP -> done next cycle, retired + 1.
- Wrap: preload 0xFFFF retirements via NOPs, then one more -> retired = 0x0000.
